// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial sequence detector: Mealy match on a {history, x} window,
// saturating match counter, registered config-error pulse. z has zero latency; no backpressure.
module seq_detector_prog #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 16,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(8'b0000_0110),
  parameter int                 RST_LEN     = 4,
  parameter bit                 RST_OVERLAP = 1'b1,
  localparam int                LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x,
  input  logic               x_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               z,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic [MAX_LEN-2:0] history_q;
  logic [LEN_W-1:0]   seen_q;

  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;
  logic               seen_ok;
  logic               match;
  logic               cfg_ok;
  logic               bit_take;

  assign window = {history_q, x};

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len_q));
    end
  end

  // seen+1 >= len avoids the len-1 underflow form
  assign seen_ok  = (int'(seen_q) + 1) >= int'(len_q);
  assign match    = x_valid & ~cfg_load & seen_ok & (((window ^ pattern_q) & mask) == '0);
  assign z        = match & ~reset;
  assign cfg_ok   = (cfg_len != '0) && (int'(cfg_len) <= MAX_LEN);
  assign bit_take = x_valid & ~cfg_load;

  // Configuration registers and error pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern_q <= RST_PATTERN;
      len_q     <= LEN_W'(RST_LEN);
      overlap_q <= RST_OVERLAP;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= cfg_load & ~cfg_ok;
      if (cfg_load && cfg_ok) begin
        pattern_q <= cfg_pattern;
        len_q     <= cfg_len;
        overlap_q <= cfg_overlap;
      end
    end
  end

  // Bit history and qualified-bit counter; a rejected load leaves both untouched
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      history_q <= '0;
      seen_q    <= '0;
    end else if (cfg_load) begin
      if (cfg_ok) begin
        history_q <= '0;
        seen_q    <= '0;
      end
    end else if (bit_take) begin
      history_q <= window[MAX_LEN-2:0];
      if (match && !overlap_q) begin
        seen_q <= '0;
      end else if (seen_q != LEN_W'(MAX_LEN)) begin
        seen_q <= seen_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_count <= '0;
    end else if (cnt_clr) begin
      match_count <= '0;
    end else if (match && (match_count != {CNT_W{1'b1}})) begin
      match_count <= match_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_detector_prog.sv
// Bench for seq_detector_prog: default and 4-bit-counter instances share all inputs.
module tb_seq_detector_prog;

  logic       clk = 1'b0;
  logic       reset;
  logic       x;
  logic       x_valid;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       cnt_clr;

  logic        z;
  logic [15:0] match_count;
  logic        cfg_err;
  logic        z4;
  logic [3:0]  match_count4;
  logic        cfg_err4;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;

  logic exp_q[$];
  logic obs_q[$];

  always #5 clk = ~clk;

  seq_detector_prog dut (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .z(z), .match_count(match_count), .cfg_err(cfg_err)
  );

  seq_detector_prog #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .z(z4), .match_count(match_count4), .cfg_err(cfg_err4)
  );

  // Drive one cycle of input, queue the expected z and capture the observed z mid-cycle.
  task automatic step(input logic v, input logic b, input logic e);
    x_valid = v;
    x       = b;
    exp_q.push_back(e);
    @(negedge clk);
    obs_q.push_back(z);
    @(posedge clk);
    #1;
    x_valid = 1'b0;
  endtask

  task automatic load_cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
    cfg_load    = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    x_valid = 1'b1;
    x = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (z !== 1'b0) begin n_err++; $display("FAIL reset_z: got %b want 0", z); end
    n_cmp++;
    if (match_count !== 16'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", match_count); end
    n_cmp++;
    if (cfg_err !== 1'b0) begin n_err++; $display("FAIL reset_cfg_err: got %b want 0", cfg_err); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    x_valid = 1'b0;
  endtask

  task automatic test_default_overlap;
    logic [6:0] bits = 7'b0110110;
    logic [6:0] want = 7'b0001001;
    int idx = 0;
    logic e, o;
    for (int i = 6; i >= 0; i--) step(1'b1, bits[i], want[i]);
    exp_cnt += 2;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL overlap_z[%0d]: got %b want %b", idx, o, e); end
      idx++;
    end
    n_cmp++;
    if (match_count !== 16'(exp_cnt)) begin n_err++; $display("FAIL overlap_count: got %0d want %0d", match_count, exp_cnt); end
  endtask

  task automatic test_non_overlap;
    logic [10:0] bits = 11'b0110_1100_110;
    logic [10:0] want = 11'b0001_0000_001;
    int idx = 0;
    logic e, o;
    load_cfg(8'b0000_0110, 4'd4, 1'b0);
    for (int i = 10; i >= 0; i--) step(1'b1, bits[i], want[i]);
    exp_cnt += 2;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL nonovl_z[%0d]: got %b want %b", idx, o, e); end
      idx++;
    end
    n_cmp++;
    if (match_count !== 16'(exp_cnt)) begin n_err++; $display("FAIL nonovl_count: got %0d want %0d", match_count, exp_cnt); end
  endtask

  task automatic test_gaps_full_len;
    logic [7:0] bits = 8'hA5;
    int idx = 0;
    logic e, o;
    load_cfg(8'hA5, 4'd8, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      step(1'b1, bits[i], (i == 0));
      if (i != 0) for (int g = 0; g < 3; g++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end
    exp_cnt += 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL gaps_z[%0d]: got %b want %b", idx, o, e); end
      idx++;
    end
    n_cmp++;
    if (match_count !== 16'(exp_cnt)) begin n_err++; $display("FAIL gaps_count: got %0d want %0d", match_count, exp_cnt); end
  endtask

  task automatic test_cfg_err;
    logic [3:0] bad [2] = '{4'd0, 4'd9};
    int idx = 0;
    logic e, o;
    load_cfg(8'b0000_0110, 4'd4, 1'b1);
    for (int k = 0; k < 2; k++) begin
      load_cfg(8'hFF, bad[k], 1'b0);
      n_cmp++;
      if (cfg_err !== 1'b1) begin n_err++; $display("FAIL cfg_err_pulse len=%0d: got %b want 1", bad[k], cfg_err); end
      @(posedge clk);
      #1;
      n_cmp++;
      if (cfg_err !== 1'b0) begin n_err++; $display("FAIL cfg_err_clear len=%0d: got %b want 0", bad[k], cfg_err); end
    end
    // old 0110 config must still detect
    step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b1);
    exp_cnt += 1;
    // rejected load collides with the completing bit: bit dropped, history kept
    step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
    cfg_load = 1'b1; cfg_len = 4'd0; cfg_pattern = 8'hFF;
    step(1'b1, 1'b0, 1'b0);
    cfg_load = 1'b0;
    n_cmp++;
    if (cfg_err !== 1'b1) begin n_err++; $display("FAIL collide_cfg_err: got %b want 1", cfg_err); end
    n_cmp++;
    if (match_count !== 16'(exp_cnt)) begin n_err++; $display("FAIL collide_count: got %0d want %0d", match_count, exp_cnt); end
    step(1'b1, 1'b0, 1'b1);
    exp_cnt += 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL cfgerr_z[%0d]: got %b want %b", idx, o, e); end
      idx++;
    end
    n_cmp++;
    if (match_count !== 16'(exp_cnt)) begin n_err++; $display("FAIL cfgerr_count: got %0d want %0d", match_count, exp_cnt); end
  endtask

  task automatic test_saturate_clear;
    int idx = 0;
    logic e, o;
    load_cfg(8'h01, 4'd1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    exp_cnt += 20;
    n_cmp++;
    if (match_count4 !== 4'd15) begin n_err++; $display("FAIL sat_count4: got %0d want 15", match_count4); end
    n_cmp++;
    if (match_count !== 16'(exp_cnt)) begin n_err++; $display("FAIL sat_count16: got %0d want %0d", match_count, exp_cnt); end
    cnt_clr = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    cnt_clr = 1'b0;
    exp_cnt = 0;
    n_cmp++;
    if (match_count4 !== 4'd0) begin n_err++; $display("FAIL clr_count4: got %0d want 0", match_count4); end
    n_cmp++;
    if (match_count !== 16'd0) begin n_err++; $display("FAIL clr_count16: got %0d want 0", match_count); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL sat_z[%0d]: got %b want %b", idx, o, e); end
      idx++;
    end
  endtask

  task automatic test_reset_partial;
    int idx = 0;
    logic e, o;
    // still len=1 pattern=1: the two 1s match
    step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b1); step(1'b1, 1'b1, 1'b1);
    exp_cnt += 2;
    n_cmp++;
    if (match_count !== 16'(exp_cnt)) begin n_err++; $display("FAIL prereset_count: got %0d want %0d", match_count, exp_cnt); end
    reset = 1'b1;
    x_valid = 1'b1;
    x = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (z !== 1'b0) begin n_err++; $display("FAIL inreset_z: got %b want 0", z); end
    n_cmp++;
    if (match_count !== 16'd0) begin n_err++; $display("FAIL inreset_count: got %0d want 0", match_count); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    x_valid = 1'b0;
    exp_cnt = 0;
    step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b1);
    exp_cnt += 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL postreset_z[%0d]: got %b want %b", idx, o, e); end
      idx++;
    end
    n_cmp++;
    if (match_count !== 16'(exp_cnt)) begin n_err++; $display("FAIL postreset_count: got %0d want %0d", match_count, exp_cnt); end
  endtask

  initial begin
    reset = 1'b1;
    x = 1'b0;
    x_valid = 1'b0;
    cfg_load = 1'b0;
    cfg_pattern = 8'h00;
    cfg_len = 4'd0;
    cfg_overlap = 1'b0;
    cnt_clr = 1'b0;
    test_reset;
    test_default_overlap;
    test_non_overlap;
    test_gaps_full_len;
    test_cfg_err;
    test_saturate_clear;
    test_reset_partial;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detector_prog.md
Name: seq_detector_prog

Overview:
- Runtime-programmable serial bit-sequence detector, one bit per qualified clock. Parametrised successor of the team's fixed "0110" Mealy detector.
- Pattern length 1..MAX_LEN, pattern value and overlap/non-overlap mode are loaded at run time.
- Adds an input qualifier, a saturating match counter and config-error reporting.
- Sits between a serial deserialiser/bit source and the control/status register block.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- CNT_W, 16, width of the match counter.
- RST_PATTERN, 8'b0000_0110, pattern value after reset; low MAX_LEN bits are used.
- RST_LEN, 4, pattern length after reset (1..MAX_LEN).
- RST_OVERLAP, 1, overlap mode after reset.
- LEN_W (localparam), $clog2(MAX_LEN+1).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- x  input  1  serial data bit.
- x_valid  input  1  x is sampled only in cycles where this is 1.
- cfg_load  input  1  one-cycle strobe to load cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern  input  MAX_LEN  pattern; bit cfg_len-1 is the first bit received, bit 0 the last.
- cfg_len  input  LEN_W  pattern length.
- cfg_overlap  input  1  1 = overlapping matches, 0 = non-overlapping.
- cnt_clr  input  1  synchronous clear of match_count.
- z  output  1  Mealy match output, combinational.
- match_count  output  CNT_W  saturating count of matches (registered).
- cfg_err  output  1  one-cycle pulse when a load is rejected (registered).

Behaviour:
- Reset is asynchronous and active-high; clock is clk.
- Reset values: pattern=RST_PATTERN, len=RST_LEN, overlap=RST_OVERLAP, history=0, seen=0, match_count=0, cfg_err=0.
- After reset the block behaves as an overlapping "0110" detector.
- State:
  - history shift register, MAX_LEN-1 bits.
  - seen counter: qualified bits accepted since the last clear, saturating at MAX_LEN.
- Window: w = {history, x}.
- Combinational match: x_valid & !cfg_load & (seen >= len-1) & ((w ^ pattern) & mask) == 0, where mask has its low len bits set.
- z = match. z is Mealy, so it asserts in the same cycle as the final pattern bit, with zero latency. z=0 whenever x_valid=0.
- On a qualified bit (x_valid=1, cfg_load=0):
  - history <= w[MAX_LEN-2:0].
  - seen <= min(seen+1, MAX_LEN).
  - On a match with overlap=0: seen <= 0; history is don't-care. The next match needs len fresh bits.
  - On a match with overlap=1: history and seen advance normally.
- x_valid=0: no state change; gaps between bits are transparent.
- match_count:
  - Increments by 1 on each cycle with z=1.
  - Holds at 2^CNT_W-1 (saturates; never wraps).
  - cnt_clr=1 forces it to 0. When a match and cnt_clr occur in the same cycle, the clear wins and the result is 0.
- cfg_load:
  - Accepted if 1 <= cfg_len <= MAX_LEN. Then pattern, len and overlap are updated, seen <= 0 and history <= 0 on the next edge. match_count is unaffected.
  - Rejected if cfg_len==0 or cfg_len>MAX_LEN. The old config is kept, history and seen are untouched, and cfg_err=1 for the following cycle only.
  - When cfg_load and x_valid are both 1, the config takes priority: the bit is discarded and z=0, for both accepted and rejected loads.
- len=1: every qualified bit equal to pattern[0] matches. Overlap mode makes no difference.
- len=MAX_LEN: the full window is compared; seen must reach MAX_LEN-1 first.
- Reset during a partial match: the partial match is abandoned and the reset config is restored immediately (asynchronously). z=0 while reset is high.

Test Plan:
- After reset, x_valid=1, x stream 0,1,1,0,1,1,0 -> z=1 on the 4th and 7th bits; match_count=2.
- Load pattern=0110, len=4, overlap=0. Stream 0,1,1,0,1,1,0,0,1,1,0 -> z only on bits 4 and 11; match_count increments by 2.
- Load len=8, pattern=8'hA5. Stream 1,0,1,0,0,1,0,1 with x_valid=0 gaps of 3 cycles between bits -> single z=1 on the last bit; no z during the gaps.
- Load cfg_len=0, then cfg_len=9 (MAX_LEN=8) -> cfg_err pulses 1 cycle each; the old "0110" detection still works. cfg_load with x_valid=1 and x=0 completing "0110" -> z=0, no count.
- CNT_W=4, 20 matches with len=1, pattern=1 -> match_count stops at 15. Assert cnt_clr in the same cycle as a match -> match_count=0.
- Assert reset after bits 0,1,1 -> after release, bit 0 alone gives no z; a full 0,1,1,0 is required again.
